// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: DataMemory command encodings and the dump FSM state type.
package mips_pkg;

    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_WRITE = 2'b01;
    localparam logic [1:0] MEM_READ  = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StPresent,
        StDone
    } dumpStateT;

endpackage

// File: rtl/dmem_port_mux.sv
// Combinational DataMemory port select between the pipeline and the dump engine.
module dmem_port_mux
    import mips_pkg::*;
(
    input  logic        sel,
    input  logic [1:0]  pipeReadWrite,
    input  logic [31:0] pipeAddress,
    input  logic [31:0] pipeWdata,
    input  logic [1:0]  dumpReadWrite,
    input  logic [31:0] dumpAddress,
    output logic [1:0]  memReadWrite,
    output logic [31:0] memAddress,
    output logic [31:0] memWdata
);

    always_comb begin
        if (sel) begin
            memReadWrite = dumpReadWrite;
            memAddress   = dumpAddress;
            memWdata     = 32'h0;
        end else begin
            // 2'b11 is not a legal command; the memory must see it as idle
            memReadWrite = (pipeReadWrite == 2'b11) ? MEM_IDLE : pipeReadWrite;
            memAddress   = pipeAddress;
            memWdata     = pipeWdata;
        end
    end

endmodule

// File: rtl/dmem_dump_arbiter.sv
// DataMemory port arbiter: pipeline pass-through, or a sequential debug dump of DEPTH words
// streamed over valid/ready while the pipeline is frozen.
module dmem_dump_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH     = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stop_debug,
    input  logic        dump_start,
    input  logic [1:0]  pipe_read_write,
    input  logic [31:0] pipe_address,
    input  logic [31:0] pipe_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  mem_read_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [31:0] pipe_rdata,
    output logic        dump_valid,
    output logic [31:0] dump_data,
    input  logic        dump_ready,
    output logic        dump_busy,
    output logic        dump_done,
    output logic        dump_abort
);

    localparam int unsigned   IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);
    localparam logic [1:0]    LatInit = 2'(MEM_LAT - 1);

    dumpStateT       stateQ, stateD;
    logic [IdxW-1:0] idxQ, idxD;
    logic [1:0]      latCntQ, latCntD;
    logic [31:0]     dataQ, dataD;

    logic            dumpSel;
    logic            engaged;
    logic [1:0]      dumpReadWrite;
    logic [31:0]     dumpAddress;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ  <= StIdle;
            idxQ    <= '0;
            latCntQ <= 2'd0;
            dataQ   <= 32'h0;
        end else begin
            stateQ  <= stateD;
            idxQ    <= idxD;
            latCntQ <= latCntD;
            dataQ   <= dataD;
        end
    end

    assign engaged = (stateQ == StIssue) || (stateQ == StWait) || (stateQ == StPresent);

    always_comb begin
        stateD        = stateQ;
        idxD          = idxQ;
        latCntD       = latCntQ;
        dataD         = dataQ;
        dumpReadWrite = MEM_IDLE;
        dump_abort    = 1'b0;
        case (stateQ)
            StIdle: begin
                if (dump_start && stop_debug) begin
                    stateD = StIssue;
                    idxD   = '0;
                end
            end
            StIssue: begin
                dumpReadWrite = MEM_READ;
                latCntD       = LatInit;
                stateD        = StWait;
            end
            StWait: begin
                if (latCntQ == 2'd0) begin
                    dataD  = mem_rdata;
                    stateD = StPresent;
                end else begin
                    latCntD = latCntQ - 2'd1;
                end
            end
            StPresent: begin
                if (dump_ready) begin
                    if (idxQ == LastIdx) begin
                        stateD = StDone;
                    end else begin
                        idxD   = idxQ + 1'b1;
                        stateD = StIssue;
                    end
                end
            end
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
        // Releasing the pipeline cancels the dump and overrides any handshake this cycle
        if (engaged && !stop_debug) begin
            stateD     = StIdle;
            idxD       = '0;
            dump_abort = 1'b1;
        end
    end

    assign dumpSel     = engaged;
    assign dumpAddress = BASE_ADDR + (32'(idxQ) << 2);

    dmem_port_mux u_port_mux (
        .sel           (dumpSel),
        .pipeReadWrite (pipe_read_write),
        .pipeAddress   (pipe_address),
        .pipeWdata     (pipe_wdata),
        .dumpReadWrite (dumpReadWrite),
        .dumpAddress   (dumpAddress),
        .memReadWrite  (mem_read_write),
        .memAddress    (mem_address),
        .memWdata      (mem_wdata)
    );

    assign pipe_rdata = mem_rdata;
    assign dump_valid = (stateQ == StPresent) && stop_debug;
    assign dump_data  = dataQ;
    assign dump_busy  = (stateQ != StIdle);
    assign dump_done  = (stateQ == StDone);

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Self-checking bench for dmem_dump_arbiter: memory model, transaction scoreboard, directed tests.
module tb_dmem_dump_arbiter;
    import mips_pkg::*;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MEM_LAT   = 1;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stop_debug, dump_start, dump_ready;
    logic [1:0]  pipe_read_write;
    logic [31:0] pipe_address, pipe_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_read_write;
    logic [31:0] mem_address, mem_wdata, pipe_rdata, dump_data;
    logic        dump_valid, dump_busy, dump_done, dump_abort;

    logic [31:0] memArr [64];
    logic [31:0] rdAddrQ = 32'h0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issueIdx = 0, acceptIdx = 0;
    int issueCnt, acceptCnt, doneCnt, abortCnt, busyCnt, lastAcceptCyc, startCyc;
    int acceptCyc [DEPTH];
    logic        prevHold = 1'b0;
    logic [31:0] prevData = 32'h0;

    dmem_dump_arbiter #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .MEM_LAT   (MEM_LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stop_debug      (stop_debug),
        .dump_start      (dump_start),
        .pipe_read_write (pipe_read_write),
        .pipe_address    (pipe_address),
        .pipe_wdata      (pipe_wdata),
        .mem_rdata       (mem_rdata),
        .mem_read_write  (mem_read_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .pipe_rdata      (pipe_rdata),
        .dump_valid      (dump_valid),
        .dump_data       (dump_data),
        .dump_ready      (dump_ready),
        .dump_busy       (dump_busy),
        .dump_done       (dump_done),
        .dump_abort      (dump_abort)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // DataMemory with one cycle read latency
    always @(posedge clk) begin
        if (mem_read_write == MEM_READ)  rdAddrQ <= mem_address;
        if (mem_read_write == MEM_WRITE) memArr[mem_address[7:2]] <= mem_wdata;
    end
    assign mem_rdata = memArr[rdAddrQ[7:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pass-through when idle, read addresses and word stream during a dump
    always @(negedge clk) begin
        if (rst) begin
            issueIdx = 0;
            acceptIdx = 0;
            prevHold = 1'b0;
        end else begin
            check("pipe_rdata mirror", pipe_rdata, mem_rdata);
            if (!dump_busy) begin
                check("pass rw", {30'b0, mem_read_write},
                      {30'b0, (pipe_read_write == 2'b11) ? 2'b00 : pipe_read_write});
                check("pass addr", mem_address, pipe_address);
                check("pass wdata", mem_wdata, pipe_wdata);
            end else begin
                busyCnt++;
                check("no write while busy", {31'b0, mem_read_write == MEM_WRITE}, 32'd0);
                if (mem_read_write == MEM_READ) begin
                    check("issue addr", mem_address, BASE_ADDR + 32'(issueIdx) * 4);
                    issueIdx++;
                    issueCnt++;
                end
            end
            if (prevHold && stop_debug) begin
                check("held valid", {31'b0, dump_valid}, 32'd1);
                check("held data", dump_data, prevData);
            end
            if (dump_valid && dump_ready) begin
                check("dump word", dump_data, 32'h100 + 32'(acceptIdx));
                if (acceptIdx < DEPTH) acceptCyc[acceptIdx] = cyc;
                acceptIdx++;
                acceptCnt++;
                lastAcceptCyc = cyc;
            end
            prevHold = dump_valid && !dump_ready;
            prevData = dump_data;
            if (dump_done) begin
                check("done after last word", 32'(acceptIdx), DEPTH);
                check("done timing", 32'(cyc), 32'(lastAcceptCyc + 1));
                doneCnt++;
                issueIdx = 0;
                acceptIdx = 0;
            end
            if (dump_abort) begin
                abortCnt++;
                issueIdx = 0;
                acceptIdx = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearCounts();
        issueCnt = 0; acceptCnt = 0; doneCnt = 0; abortCnt = 0; busyCnt = 0;
    endtask

    task automatic pulseStart();
        startCyc = cyc;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    task automatic waitDone();
        for (int k = 0; k < 200 && doneCnt == 0; k++) tick();
        check("dump_done seen", 32'(doneCnt), 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) memArr[i] = (i < DEPTH) ? 32'h100 + 32'(i) : 32'h0;
        rst = 1'b1; stop_debug = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
        pipe_read_write = 2'b00; pipe_address = 32'h0; pipe_wdata = 32'h0;
        clearCounts();
        #12;
        check("reset busy", {31'b0, dump_busy}, 32'd0);
        check("reset valid", {31'b0, dump_valid}, 32'd0);
        check("reset done", {31'b0, dump_done}, 32'd0);
        check("reset data", dump_data, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Pass-through
        pipe_read_write = 2'b01; pipe_address = 32'h10; pipe_wdata = 32'hDEADBEEF;
        #1;
        check("pt write rw", {30'b0, mem_read_write}, 32'd1);
        check("pt write addr", mem_address, 32'h10);
        check("pt write data", mem_wdata, 32'hDEADBEEF);
        tick();
        pipe_read_write = 2'b11;
        #1;
        check("pt 11 as idle", {30'b0, mem_read_write}, 32'd0);
        tick();
        pipe_read_write = 2'b00;
        tick();

        // Gating: start ignored while the pipeline runs
        clearCounts();
        pulseStart();
        repeat (3) tick();
        check("gated busy cycles", 32'(busyCnt), 32'd0);

        // Full dump, a mid-dump start and a start in the DONE cycle
        clearCounts();
        stop_debug = 1'b1; dump_ready = 1'b1;
        tick();
        pulseStart();
        check("first issue rw", {30'b0, mem_read_write}, {30'b0, MEM_READ});
        check("first issue addr", mem_address, BASE_ADDR);
        repeat (3) tick();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int k = 0; k < 200 && !dump_done; k++) tick();
        check("done reached", {31'b0, dump_done}, 32'd1);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        check("idle after done", {31'b0, dump_busy}, 32'd0);
        tick();
        check("done-cycle start ignored", {31'b0, dump_busy}, 32'd0);
        check("full accepts", 32'(acceptCnt), DEPTH);
        check("full issues", 32'(issueCnt), DEPTH);
        check("full done count", 32'(doneCnt), 32'd1);
        check("full busy cycles", 32'(busyCnt), 32'd13);
        check("first accept cycle", 32'(acceptCyc[0]), 32'(startCyc + 3));
        for (int i = 1; i < DEPTH; i++)
            check("word spacing", 32'(acceptCyc[i] - acceptCyc[i-1]), 32'd3);

        // Backpressure on word 1
        clearCounts();
        pulseStart();
        for (int k = 0; k < 50 && acceptCnt < 1; k++) tick();
        dump_ready = 1'b0;
        for (int k = 0; k < 50 && !dump_valid; k++) tick();
        check("bp word1 valid", {31'b0, dump_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("bp data stable", dump_data, 32'h101);
            check("bp no new read", 32'(issueCnt), 32'd2);
            tick();
        end
        dump_ready = 1'b1;
        waitDone();
        check("bp accepts", 32'(acceptCnt), DEPTH);
        check("bp issues", 32'(issueCnt), DEPTH);
        check("bp aborts", 32'(abortCnt), 32'd0);

        // Abort during WAIT of word 2, then a pipeline write
        clearCounts();
        pulseStart();
        for (int k = 0; k < 50 && issueCnt < 3; k++) tick();
        stop_debug = 1'b0;
        #1;
        check("abort pulse", {31'b0, dump_abort}, 32'd1);
        check("abort valid low", {31'b0, dump_valid}, 32'd0);
        tick();
        check("abort idle", {31'b0, dump_busy}, 32'd0);
        check("abort one cycle", {31'b0, dump_abort}, 32'd0);
        pipe_read_write = 2'b01; pipe_address = 32'h20; pipe_wdata = 32'hCAFEF00D;
        #1;
        check("post-abort rw", {30'b0, mem_read_write}, 32'd1);
        check("post-abort addr", mem_address, 32'h20);
        tick();
        pipe_read_write = 2'b00;
        check("post-abort mem word", memArr[8], 32'hCAFEF00D);
        repeat (3) tick();
        check("abort no done", 32'(doneCnt), 32'd0);
        check("abort count", 32'(abortCnt), 32'd1);
        check("abort accepts", 32'(acceptCnt), 32'd2);

        // Async reset mid-PRESENT, then a fresh dump
        clearCounts();
        stop_debug = 1'b1; dump_ready = 1'b0;
        pulseStart();
        for (int k = 0; k < 50 && !dump_valid; k++) tick();
        check("pre-reset valid", {31'b0, dump_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst valid", {31'b0, dump_valid}, 32'd0);
        check("async rst busy", {31'b0, dump_busy}, 32'd0);
        check("async rst abort", {31'b0, dump_abort}, 32'd0);
        #3 rst = 1'b0;
        tick();
        dump_ready = 1'b1;
        pulseStart();
        check("restart addr", mem_address, BASE_ADDR);
        waitDone();
        check("restart accepts", 32'(acceptCnt), DEPTH);
        check("restart aborts", 32'(abortCnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
